// File: rtl/udp_ctrl_pkg.sv
// Shared types and constants for the UDP loopback transmit sequencer.
// Holds the FSM state enum, the field widths and the byte-to-word rounding helper.
package udp_ctrl_pkg;

    localparam int unsigned BYTE_W     = 16;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned WORD_CNT_W = 10;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWaitDone,
        StGap
    } state_e;

    // Payload is moved in 32-bit words, so a partial last word still costs a request.
    function automatic logic [BYTE_W-1:0] bytes_to_words(input logic [BYTE_W-1:0] b);
        logic [BYTE_W:0] w_sum;
        w_sum = {1'b0, b} + (BYTE_W+1)'(3);
        return {1'b0, w_sum[BYTE_W:2]};
    endfunction

endpackage

// File: rtl/udp_loop_ctrl_if.sv
// Rx status / tx control bundle between the UDP core and the loopback sequencer.
// The sequencer uses the slave view; the UDP core side uses the master view.
interface udp_loop_ctrl_if;
    import udp_ctrl_pkg::*;

    logic              rx_pkg_done;
    logic [BYTE_W-1:0] rx_byte_num;
    logic              tx_req;
    logic              tx_pkg_done;
    logic              tx_start_en;
    logic [BYTE_W-1:0] tx_byte_num;
    logic              busy;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  pkt_cnt;
    logic              timeout_err;
    logic              len_err;

    modport master (
        output rx_pkg_done, rx_byte_num, tx_req, tx_pkg_done,
        input  tx_start_en, tx_byte_num, busy, drop_cnt, pkt_cnt, timeout_err, len_err
    );

    modport slave (
        input  rx_pkg_done, rx_byte_num, tx_req, tx_pkg_done,
        output tx_start_en, tx_byte_num, busy, drop_cnt, pkt_cnt, timeout_err, len_err
    );

endinterface

// File: rtl/udp_desc_fifo.sv
// Single-clock descriptor FIFO with wrap-bit pointers and a registered head word.
// A push while full is accepted only when a pop happens in the same cycle.
module udp_desc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_head;

    logic             w_push;
    logic             w_pop;
    logic [AW:0]      w_rd_nxt;

    assign o_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_pop    = i_pop && !o_empty;
    assign w_push   = i_push && (!o_full || w_pop);
    assign w_rd_nxt = w_pop ? r_rd_ptr + (AW+1)'(1) : r_rd_ptr;
    assign o_head   = r_head;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            r_rd_ptr <= w_rd_nxt;
            // Bypass the write when the new entry becomes the head in the same cycle.
            if (w_push && (r_wr_ptr[AW-1:0] == w_rd_nxt[AW-1:0])) begin
                r_head <= i_wdata;
            end else begin
                r_head <= r_mem[w_rd_nxt[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/udp_loop_ctrl.sv
// Loopback transmit sequencer: queues rx descriptors, starts one tx per descriptor,
// supervises it until done or timeout, checks the word count and enforces a gap.
module udp_loop_ctrl
    import udp_ctrl_pkg::*;
#(
    parameter int unsigned DESC_DEPTH     = 4,
    parameter int unsigned GAP_CYCLES     = 12,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned MAX_BYTES      = 1472
) (
    input  logic           clk,
    input  logic           rst,
    udp_loop_ctrl_if.slave io_bus
);

    localparam int unsigned      GAP_W    = $clog2(GAP_CYCLES) + 1;
    localparam int unsigned      TMR_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    // The timer value is compared before its increment, so fire one count early.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 2);

    state_e                r_state;
    logic [BYTE_W-1:0]     r_tx_byte_num;
    logic [CNT_W-1:0]      r_drop_cnt;
    logic [CNT_W-1:0]      r_pkt_cnt;
    logic [WORD_CNT_W-1:0] r_word_cnt;
    logic [TMR_W-1:0]      r_timer;
    logic [GAP_W-1:0]      r_gap_cnt;
    logic                  r_tx_start_en;
    logic                  r_busy;
    logic                  r_timeout_err;
    logic                  r_len_err;

    logic                  w_len_ok;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [BYTE_W-1:0]     w_head;
    logic [WORD_CNT_W-1:0] w_words_fin;
    logic                  w_len_mismatch;

    assign w_len_ok    = (io_bus.rx_byte_num != '0) &&
                         (io_bus.rx_byte_num <= BYTE_W'(MAX_BYTES));
    assign w_pop       = (r_state == StIdle) && !w_empty;
    assign w_push      = io_bus.rx_pkg_done && w_len_ok && (!w_full || w_pop);
    assign w_drop      = io_bus.rx_pkg_done && !w_push;
    assign w_words_fin = (io_bus.tx_req && (r_word_cnt != '1)) ?
                         r_word_cnt + WORD_CNT_W'(1) : r_word_cnt;
    assign w_len_mismatch = BYTE_W'(w_words_fin) != bytes_to_words(r_tx_byte_num);

    udp_desc_fifo #(
        .DEPTH (DESC_DEPTH),
        .WIDTH (BYTE_W)
    ) u_desc_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (io_bus.rx_byte_num),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_tx_byte_num <= '0;
            r_drop_cnt    <= '0;
            r_pkt_cnt     <= '0;
            r_word_cnt    <= '0;
            r_timer       <= '0;
            r_gap_cnt     <= '0;
            r_tx_start_en <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_len_err     <= 1'b0;
        end else begin
            r_tx_start_en <= 1'b0;
            r_timeout_err <= 1'b0;
            r_len_err     <= 1'b0;
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
            unique case (r_state)
                StIdle: begin
                    if (!w_empty) begin
                        r_tx_byte_num <= w_head;
                        r_tx_start_en <= 1'b1;
                        r_state       <= StStart;
                        r_busy        <= 1'b1;
                    end else begin
                        r_busy <= w_push;
                    end
                end
                StStart: begin
                    r_word_cnt <= '0;
                    r_timer    <= '0;
                    r_state    <= StWaitDone;
                    r_busy     <= 1'b1;
                end
                StWaitDone: begin
                    r_timer    <= r_timer + TMR_W'(1);
                    r_word_cnt <= w_words_fin;
                    r_busy     <= 1'b1;
                    if (io_bus.tx_pkg_done) begin
                        r_len_err <= w_len_mismatch;
                        r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
                        r_gap_cnt <= '0;
                        r_state   <= StGap;
                    end else if (r_timer == TMR_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_pkt_cnt     <= r_pkt_cnt + CNT_W'(1);
                        r_gap_cnt     <= '0;
                        r_state       <= StGap;
                    end
                end
                StGap: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= StIdle;
                        r_busy  <= !w_empty || w_push;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                        r_busy    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign io_bus.tx_start_en = r_tx_start_en;
    assign io_bus.tx_byte_num = r_tx_byte_num;
    assign io_bus.busy        = r_busy;
    assign io_bus.drop_cnt    = r_drop_cnt;
    assign io_bus.pkt_cnt     = r_pkt_cnt;
    assign io_bus.timeout_err = r_timeout_err;
    assign io_bus.len_err     = r_len_err;

endmodule

// File: tb/tb_udp_loop_ctrl.sv
// Bench for udp_loop_ctrl: directed scenarios plus random traffic, every output compared
// each cycle against a timestamp-based model of queue, transmit window and gap.
module tb_udp_loop_ctrl;

    localparam int D    = 4;
    localparam int GAP  = 12;
    localparam int TO   = 16;
    localparam int MAXB = 1472;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    udp_loop_ctrl_if bus ();

    udp_loop_ctrl #(
        .DESC_DEPTH     (D),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO),
        .MAX_BYTES      (MAXB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of descriptors, active transmission start time s, and the first cycle
    // from which the sequencer may pop again. Cycle m_cyc starts at the current edge.
    int unsigned m_q[$];
    bit          m_valid = 1'b0;
    bit          m_act   = 1'b0;
    int          m_cyc   = 0;
    int          m_s     = 0;
    int          m_p     = 0;
    int          m_idle_from = 0;
    int          m_words = 0;
    int          m_bytes = 0;
    logic        e_start, e_to, e_len, e_busy;
    logic [15:0] e_bytes, e_drop, e_pkt;

    always @(posedge clk) begin
        m_cyc++;
        m_p     = m_cyc - 1;
        e_start = 1'b0;
        e_to    = 1'b0;
        e_len   = 1'b0;
        if (rst) begin
            m_q.delete();
            m_act       = 1'b0;
            m_idle_from = m_cyc;
            e_bytes     = '0;
            e_drop      = '0;
            e_pkt       = '0;
            m_valid     = 1'b1;
        end else if (m_valid) begin
            // Wait window spans s+1 .. s+TO-1; the START cycle ignores tx inputs.
            if (m_act && m_p > m_s) begin
                if (bus.tx_req && m_words < 1023) m_words++;
                if (bus.tx_pkg_done) begin
                    e_len       = (m_words != (m_bytes + 3) / 4);
                    e_pkt       = e_pkt + 16'd1;
                    m_act       = 1'b0;
                    m_idle_from = m_p + GAP + 1;
                end else if (m_p == m_s + TO - 1) begin
                    e_to        = 1'b1;
                    e_pkt       = e_pkt + 16'd1;
                    m_act       = 1'b0;
                    m_idle_from = m_p + GAP + 1;
                end
            end
            if (!m_act && m_p >= m_idle_from && m_q.size() > 0) begin
                m_bytes = int'(m_q.pop_front());
                e_bytes = 16'(m_bytes);
                e_start = 1'b1;
                m_act   = 1'b1;
                m_s     = m_cyc;
                m_words = 0;
            end
            if (bus.rx_pkg_done) begin
                if (bus.rx_byte_num >= 1 && bus.rx_byte_num <= MAXB && m_q.size() < D)
                    m_q.push_back(int'(bus.rx_byte_num));
                else if (e_drop != 16'hFFFF)
                    e_drop = e_drop + 16'd1;
            end
        end
        e_busy = m_act || (m_cyc < m_idle_from) || (m_q.size() > 0);
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("tx_start_en", bus.tx_start_en, e_start);
            check("tx_byte_num", bus.tx_byte_num, e_bytes);
            check("busy",        bus.busy,        e_busy);
            check("drop_cnt",    bus.drop_cnt,    e_drop);
            check("pkt_cnt",     bus.pkt_cnt,     e_pkt);
            check("timeout_err", bus.timeout_err, e_to);
            check("len_err",     bus.len_err,     e_len);
        end
    end

    task automatic step(input logic r, input logic rd, input logic [15:0] b,
                        input logic rq, input logic dn);
        @(posedge clk);
        #1;
        rst             = r;
        bus.rx_pkg_done = rd;
        bus.rx_byte_num = b;
        bus.tx_req      = rq;
        bus.tx_pkg_done = dn;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [15:0] b);
        step(1'b0, 1'b1, b, 1'b0, 1'b0);
    endtask

    // Returns the number of negedges waited (1 = start seen in the current cycle).
    task automatic wait_start(output int n);
        n = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.tx_start_en === 1'b1) begin
                n = i + 1;
                break;
            end
            idle();
        end
        if (n < 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_start: no tx_start_en within 64 cycles at %0t", $time);
        end
    endtask

    task automatic serve(input int nreq);
        for (int i = 0; i < nreq; i++) step(1'b0, 1'b0, 16'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
    endtask

    int pkt_exp = 0;
    int n;
    int nstart;

    initial begin
        rst             = 1'b1;
        bus.rx_pkg_done = 1'b0;
        bus.rx_byte_num = '0;
        bus.tx_req      = 1'b0;
        bus.tx_pkg_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst tx_start_en", bus.tx_start_en, 0);
        check("rst busy",        bus.busy,        0);
        check("rst drop_cnt",    bus.drop_cnt,    0);
        check("rst pkt_cnt",     bus.pkt_cnt,     0);

        // Single 8-byte packet: start two clocks after rx, two words, clean finish.
        push(16'd8);
        idle();
        @(negedge clk);
        check("single start early", bus.tx_start_en, 0);
        idle();
        @(negedge clk);
        check("single start",  bus.tx_start_en, 1);
        check("single bytes",  bus.tx_byte_num, 8);
        serve(2);
        pkt_exp++;
        idle();
        @(negedge clk);
        check("single pkt_cnt", bus.pkt_cnt, 32'(pkt_exp));
        check("single len_err", bus.len_err, 0);
        for (int i = 0; i < 11; i++) idle();
        @(negedge clk);
        check("single busy in gap", bus.busy, 1);
        idle();
        @(negedge clk);
        check("single busy after gap", bus.busy, 0);

        // Back-to-back descriptors 4, 5, 1472.
        push(16'd4);
        push(16'd5);
        push(16'd1472);
        wait_start(n);
        check("b2b bytes0", bus.tx_byte_num, 4);
        serve(1);
        wait_start(n);
        check("b2b bytes1", bus.tx_byte_num, 5);
        serve(2);
        idle();
        @(negedge clk);
        check("b2b 5B len_err", bus.len_err, 0);
        wait_start(n);
        check("b2b bytes2", bus.tx_byte_num, 1472);
        serve(5);
        pkt_exp += 3;

        // Overflow while stalled in WAIT_DONE, then zero and oversize descriptors.
        push(16'd8);
        wait_start(n);
        for (int i = 0; i < 6; i++) push(16'(16 + 4 * i));
        step(1'b0, 1'b1, 16'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("ovf drop_cnt", bus.drop_cnt, 2);
        step(1'b0, 1'b1, 16'd1473, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
        pkt_exp++;
        idle();
        @(negedge clk);
        check("invalid drop_cnt", bus.drop_cnt, 4);
        check("ovf pkt_cnt", bus.pkt_cnt, 32'(pkt_exp));
        for (int i = 0; i < 4; i++) begin
            wait_start(n);
            check("drain bytes", bus.tx_byte_num, 32'(16 + 4 * i));
            serve((16 + 4 * i + 3) / 4);
            pkt_exp++;
        end

        // Timeout: no tx_pkg_done; second descriptor queued during the wait.
        push(16'd100);
        wait_start(n);
        for (int k = 1; k <= 16; k++) begin
            if (k == 1) push(16'd8);
            else idle();
            @(negedge clk);
            if (k == 15) check("to early", bus.timeout_err, 0);
        end
        pkt_exp++;
        check("to pulse",   bus.timeout_err, 1);
        check("to pkt_cnt", bus.pkt_cnt, 32'(pkt_exp));
        wait_start(n);
        check("to restart spacing", 32'(n), 32'(GAP + 1));
        serve(2);
        pkt_exp++;

        // Length error, then tx_pkg_done on the timeout cycle.
        push(16'd12);
        wait_start(n);
        serve(2);
        pkt_exp++;
        idle();
        @(negedge clk);
        check("len_err pulse", bus.len_err, 1);
        idle();
        @(negedge clk);
        check("len_err single", bus.len_err, 0);
        push(16'd20);
        wait_start(n);
        for (int k = 1; k <= 14; k++) idle();
        step(1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
        pkt_exp++;
        idle();
        @(negedge clk);
        check("done@to no timeout", bus.timeout_err, 0);
        check("done@to pkt_cnt", bus.pkt_cnt, 32'(pkt_exp));
        check("done@to len_err", bus.len_err, 1);

        // Reset in WAIT_DONE with two descriptors queued.
        push(16'd40);
        wait_start(n);
        push(16'd44);
        push(16'd48);
        step(1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        check("mid rst tx_start_en", bus.tx_start_en, 0);
        check("mid rst tx_byte_num", bus.tx_byte_num, 0);
        check("mid rst busy",        bus.busy,        0);
        check("mid rst pkt_cnt",     bus.pkt_cnt,     0);
        check("mid rst drop_cnt",    bus.drop_cnt,    0);
        nstart = 0;
        for (int i = 0; i < 30; i++) begin
            idle();
            @(negedge clk);
            if (bus.tx_start_en === 1'b1) nstart++;
        end
        check("mid rst no replay", 32'(nstart), 0);

        // Random traffic including invalid sizes, stray tx inputs and rare resets.
        for (int i = 0; i < 2000; i++) begin
            logic        rd;
            logic [15:0] b;
            int          sel;
            rd  = ($urandom_range(0, 5) == 0);
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      b = 16'd0;
            else if (sel == 1) b = 16'(MAXB + 1 + int'($urandom_range(0, 100)));
            else if (sel == 2) b = 16'(MAXB);
            else               b = 16'($urandom_range(1, 64));
            step($urandom_range(0, 499) == 0, rd, b,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 11) == 0);
        end
        for (int i = 0; i < 40; i++) idle();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
